// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the uart_tx serial transmitter.
// UART_TX_PARITY_EN adds an even-parity bit and the PARITY state.
package uart_tx_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter, with full/empty flags.
// Pointers carry one extra wrap bit to distinguish full from empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a byte FIFO on a valid/ready input.
// Define UART_TX_PARITY_EN to append an even-parity bit to each frame.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DIV   = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] rdata;
    logic                 push, pop, full, empty;
    logic                 bit_end, start_ok, load;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Gating with rst_n keeps ready low while reset is held.
    assign ready    = rst_n && ena && !full;
    assign push     = valid && ready;
    assign busy     = (state_q != IDLE) || !empty;
    assign tx       = tx_q;
    assign bit_end  = (cnt_q == '0);
    assign start_ok = ena && !empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (data_in),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? CNT_LOAD : cnt_q - CW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        load    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = CNT_LOAD;
                load  = start_ok;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sh_d  = {1'b0, sh_q[DATA_BITS-1:1]};
                        tx_d  = sh_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    load    = start_ok;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Shared frame launch, used from IDLE and straight out of STOP.
        if (load) begin
            pop     = 1'b1;
            sh_d    = rdata;
            tx_d    = 1'b0;
            cnt_d   = CNT_LOAD;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^rdata;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with DIV=4, DEPTH=4.
// Frame shapes are hand-computed; a line decoder recovers sent bytes.
module tb_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB        = 11;
    localparam int FRAME_CYC = 44;
    localparam logic [FB-1:0] F_A5 = 11'h54A;
    localparam logic [FB-1:0] F_00 = 11'h400;
    localparam logic [FB-1:0] F_FF = 11'h5FE;
    localparam logic [FB-1:0] F_3C = 11'h478;
    localparam logic [FB-1:0] F_07 = 11'h60E;
`else
    localparam int FB        = 10;
    localparam int FRAME_CYC = 40;
    localparam logic [FB-1:0] F_A5 = 10'h34A;
    localparam logic [FB-1:0] F_00 = 10'h200;
    localparam logic [FB-1:0] F_FF = 10'h3FE;
    localparam logic [FB-1:0] F_3C = 10'h278;
    localparam logic [FB-1:0] F_07 = 10'h20E;
`endif

    typedef struct {
        logic [7:0]    data;
        logic [FB-1:0] frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       valid;
    logic [7:0] data_in;
    logic       ready;
    logic       tx;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] rxq[$];
    logic [7:0] rx_b;
    logic       rx_ok;

    uart_tx #(
        .DIV   (DIV),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] b);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        if (!ready) check("push_ready_timeout", int'(ready), 1);
        data_in = b;
        valid   = 1'b1;
        tick();
        valid   = 1'b0;
        data_in = 8'hC3;
    endtask

    // Samples every cycle of every bit; one comparison per bit.
    task automatic check_frame(input logic [FB-1:0] f, input string nm,
                               input bit drop_ena);
        for (int k = 0; k < FB; k++) begin
            logic bad;
            logic got;
            bad = 1'b0;
            got = 1'b0;
            for (int c = 0; c < DIV; c++) begin
                tick();
                if (k == 0 && c == 0) begin
                    valid = 1'b0;
                    if (drop_ena) ena = 1'b0;
                end
                if (tx !== f[k] && !bad) begin
                    bad = 1'b1;
                    got = tx;
                end
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s bit%0d: tx=%0b expected %0b",
                         nm, k, got, f[k]);
            end
        end
    endtask

    task automatic rx_wait(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (!rst_n) rx_ok = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                rx_ok = 1'b1;
                rx_wait(DIV / 2);
                if (tx !== 1'b0) rx_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    rx_wait(DIV);
                    rx_b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                rx_wait(DIV);
`endif
                rx_wait(DIV);
                if (rx_ok && tx === 1'b1) rxq.push_back(rx_b);
            end
        end
    end

    initial begin
        vec_t       tbl[5];
        logic [7:0] seq[6];
        int         acc, lowcnt, cyc, n;
        logic       fire, quiet;

        tbl[0] = '{8'hA5, F_A5};
        tbl[1] = '{8'h00, F_00};
        tbl[2] = '{8'hFF, F_FF};
        tbl[3] = '{8'h3C, F_3C};
        tbl[4] = '{8'h07, F_07};
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst_n   = 1'b0;
        ena     = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        tick();
        tick();
        check("rst_tx", int'(tx), 1);
        check("rst_ready", int'(ready), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", int'(ready), 1);

        for (int i = 0; i < 5; i++) begin
            push_one(tbl[i].data);
            check($sformatf("busy_accept_%02h", tbl[i].data), int'(busy), 1);
            check_frame(tbl[i].frame,
                        $sformatf("frame_%02h", tbl[i].data), 1'b0);
            check($sformatf("busy_stop_%02h", tbl[i].data), int'(busy), 1);
            tick();
            check($sformatf("busy_idle_%02h", tbl[i].data), int'(busy), 0);
            check($sformatf("tx_idle_%02h", tbl[i].data), int'(tx), 1);
        end
        check("rx_count_table", rxq.size(), 5);
        for (int i = 0; i < 5 && i < rxq.size(); i++)
            check($sformatf("rx_table_%0d", i), int'(rxq[i]), int'(tbl[i].data));

        rxq.delete();
        data_in = 8'h00;
        valid   = 1'b1;
        tick();
        data_in = 8'hFF;
        check_frame(F_00, "b2b_first", 1'b0);
        check_frame(F_FF, "b2b_second", 1'b0);
        tick();
        check("b2b_busy_idle", int'(busy), 0);

        rxq.delete();
        acc     = 0;
        lowcnt  = 0;
        cyc     = 0;
        data_in = seq[0];
        valid   = 1'b1;
        while (acc < 6 && cyc < 600) begin
            fire = ready;
            tick();
            cyc++;
            if (fire) begin
                acc++;
                if (acc == 5) check("ready_full", int'(ready), 0);
                if (acc < 6) data_in = seq[acc];
                else valid = 1'b0;
            end
            if (acc == 5 && !ready) lowcnt++;
        end
        valid = 1'b0;
        check("flow_accepts", acc, 6);
        check("ready_low_cycles", lowcnt, FRAME_CYC - 3);
        n = 0;
        while (rxq.size() < 6 && n < 400) begin
            tick();
            n++;
        end
        check("rx_count_flow", rxq.size(), 6);
        for (int i = 0; i < 6 && i < rxq.size(); i++)
            check($sformatf("rx_flow_%0d", i), int'(rxq[i]), int'(seq[i]));
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("flow_busy_idle", int'(busy), 0);

        push_one(8'h3C);
        push_one(8'h77);
        push_one(8'h88);
        repeat (15) tick();
        check("mid_bit3_tx", int'(tx), 1);
        check("mid_bit3_busy", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        check("midrst_tx", int'(tx), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(ready), 0);
        rst_n = 1'b1;
        rxq.delete();
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("quiet_after_rst", int'(quiet), 1);
        check("rx_after_rst", rxq.size(), 0);

        data_in = 8'h07;
        valid   = 1'b1;
        tick();
        data_in = 8'h3C;
        check_frame(F_07, "ena_low_frame", 1'b1);
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b1 || ready !== 1'b0) quiet = 1'b0;
        end
        check("ena_low_hold", int'(quiet), 1);
        ena = 1'b1;
        check_frame(F_3C, "ena_resume", 1'b0);
        tick();
        check("ena_busy_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide asynchronous serial transmitter for the `tt_um_toivoh_test` user design; it drives one pin of `uo_out`. Bytes arrive over a valid/ready handshake into a small FIFO and are serialised as 8N1 frames (8 data bits, no parity, 1 stop bit), LSB first, at a fixed clocks-per-bit rate. An optional parity bit can be compiled in. The cocotb bench observes the serial line through `uo_out` and decodes it.

## Interface
Parameters:
- `DIV`, default 16: clock cycles per serial bit. Must be 2 or more.
- `DEPTH`, default 4: FIFO depth in bytes. Must be a power of two, 2 or more.

Ports:
- `clk`  in  1  design clock, single clock domain.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ena`  in  1  design enable. While low, no new frame starts.
- `data_in`  in  8  byte to send.
- `valid`  in  1  `data_in` is valid.
- `ready`  out  1  FIFO can accept a byte. Reset value 0.
- `tx`  out  1  serial line, registered, idles high. Reset value 1.
- `busy`  out  1  a frame is in flight or the FIFO is non-empty. Reset value 0.

## Operation
- Handshake: a byte is accepted on a rising edge where `valid && ready`.
- `ready` = `ena && !fifo_full`. It must not depend combinationally on `valid`.
- `data_in` is ignored in any cycle where it is not accepted.
- FSM states: IDLE, START, DATA, STOP, plus PARITY when the parity feature is compiled in.
  - IDLE: `tx`=1. Moves to START when the FIFO is non-empty and `ena`=1. On that edge the FIFO is popped into the shift register and `tx` is driven to 0.
  - START: lasts DIV cycles, then moves to DATA.
  - DATA: sends 8 bits, LSB first, DIV cycles each. A bit index counts 0..7. After bit 7 it moves to STOP (or to PARITY).
  - PARITY: sends even parity (XOR of the 8 data bits) for DIV cycles, then moves to STOP.
  - STOP: `tx`=1 for DIV cycles. At the end of STOP:
    - if the FIFO is non-empty and `ena`=1, it pops and moves straight to START with no idle gap;
    - otherwise it moves to IDLE.
- Baud counter: width $clog2(DIV). It loads DIV-1 on every bit start and counts down to 0. The bit ends on the cycle the counter reads 0.
- `ena` falling mid-frame: the current frame completes unchanged; no new frame starts until `ena` is high again.
- FIFO behaviour:
  - A push and a pop in the same cycle are both honoured, and the occupancy is unchanged.
  - Pushing while full cannot happen, because `ready` is low when full.
  - Read and write pointers have log2(DEPTH)+1 bits, so full and empty can be told apart when the pointers wrap.
- Reset mid-frame: on the first edge with `rst_n`=0:
  - `tx` goes to 1 and the FSM goes to IDLE;
  - the FIFO is emptied and any partial frame is lost;
  - `ready` and `busy` are 0.

## Timing
- Accepting a byte into an empty FIFO while the FSM is in IDLE:
  - byte accepted at edge N;
  - FIFO pop at edge N+1, `tx` low from N+1;
  - first data bit from edge N+1+DIV;
  - stop bit from edge N+1+9·DIV;
  - the FSM can be back in IDLE at edge N+1+10·DIV.
- Frame length is 10·DIV cycles, or 11·DIV with parity.
- Back-to-back frames follow each other with 0 idle cycles.
- `busy` falls on the edge the FSM enters IDLE with the FIFO empty.
- With DEPTH bytes queued plus one frame in flight, the block holds DEPTH+1 bytes in total.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and each frame is 11 bits with an even-parity bit after the data bits.
- `UART_TX_PARITY_EN` undefined: frames are 8N1, and no parity logic or state encoding is generated.

## Structure
- Package `uart_tx_pkg` holds:
  - the FSM state enum `tx_state_t`;
  - constant `DATA_BITS` = 8;
  - localparam `FRAME_BITS`, which depends on the macro.
- Sub-module `uart_tx_fifo`: a synchronous FIFO with push/pop ports and full/empty flags, parameterised by width and depth. The FSM, baud counter and shift register live in `uart_tx`.

## Test plan
All scenarios use DIV=4 and DEPTH=4.
1. Reset: hold `rst_n`=0 for 2 cycles -> `tx`=1, `ready`=0, `busy`=0. After release with `ena`=1 -> `ready`=1.
2. Single byte 0xA5 -> `tx` stays low for 4 cycles starting one edge after acceptance, then sends bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. `busy` is low 41 cycles after acceptance.
3. Back-to-back 0x00 then 0xFF -> the second start bit begins exactly 40 cycles after the first, with no idle cycle.
4. Flow control: push 6 bytes continuously -> `ready` drops after the 5th acceptance (1 in flight plus 4 queued). It returns one edge after the next pop. All 6 bytes arrive in order.
5. Assert `rst_n`=0 during bit 3 of 0x3C with 2 bytes queued -> next cycle `tx`=1 and `busy`=0. No further frames start after reset is released.
6. `ena`=0 during a frame with 1 byte queued -> the current frame completes and `tx` stays high. After `ena`=1 -> the queued frame starts on the next edge. With `UART_TX_PARITY_EN` defined, byte 0x07 -> parity bit 1 and a frame of 44 cycles.
